// File: rtl/bcd_conv_sched_pkg.sv
// Shared definitions for the BCD converter scheduler.
//   - state_e         : scheduler FSM state encoding
//   - timeout_cycles  : WAIT-state timeout limit for a given digit count
//   - ch_idx_w        : width of a channel index for a given channel count
package bcd_conv_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_STORE = 2'd3
    } state_e;

    localparam int TIMEOUT_PER_DIGIT = 3;
    localparam int TIMEOUT_BASE      = 8;

    // Cycles allowed in WAIT before a conversion is declared lost.
    function automatic int timeout_cycles(input int bcd_n);
        return bcd_n * TIMEOUT_PER_DIGIT + TIMEOUT_BASE;
    endfunction

    // Channel index width; never below one bit.
    function automatic int ch_idx_w(input int ch_n);
        return (ch_n > 1) ? $clog2(ch_n) : 1;
    endfunction

endpackage

// File: rtl/bcd_conv_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req   : per-channel request vector
//   ptr   : highest-priority channel for this decision
//   grant : one-hot grant of the first requester at or after ptr
//   idx   : binary index of the granted channel
//   any   : at least one request present
module bcd_conv_sched_rr_arbiter #(
    parameter int CH_N  = 4,
    parameter int IDX_W = 2
) (
    input  logic [CH_N-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [CH_N-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Scan channels starting at ptr, wrapping, and keep the first hit.
    always_comb begin
        logic [IDX_W-1:0] kk;
        logic             hit;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        kk    = '0;
        hit   = 1'b0;
        for (int i = 0; i < CH_N; i++) begin
            kk        = IDX_W'((int'(ptr) + i) % CH_N);
            hit       = !any && req[kk];
            grant[kk] = grant[kk] | hit;
            idx       = hit ? kk : idx;
            any       = any | hit;
        end
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin scheduler sharing one signed binary-to-BCD converter among
// CH_N requesting channels; each result is latched into a per-channel
// display slot with a one-cycle update pulse.
//
// Ports:
//   clk, reset                  : clock, asynchronous active-high reset
//   req/bin_in/sign_in          : per-channel level request and its operand
//   ack                         : one-cycle pulse, channel request captured
//   conv_start/conv_bin/conv_sign : converter start pulse and held operand
//   conv_ready/conv_done_tick/conv_bcd : converter status and result
//   out_bcd/out_neg/out_valid   : per-channel latched result, sign, valid
//   upd_tick                    : one-cycle pulse when a slot is written
//   err_tick                    : one-cycle pulse on conversion timeout
//
// Optional feature: define BCD_CONV_SCHED_TIMEOUT_EN to enable the WAIT
// timeout; otherwise WAIT waits indefinitely and err_tick is tied low.
module bcd_conv_sched
    import bcd_conv_sched_pkg::*;
#(
    parameter int CH_N  = 4,
    parameter int BCD_N = 4,
    parameter int BIN_N = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CH_N-1:0]         req,
    input  logic [CH_N*BIN_N-1:0]   bin_in,
    input  logic [CH_N-1:0]         sign_in,
    output logic [CH_N-1:0]         ack,
    output logic                    conv_start,
    output logic [BIN_N-1:0]        conv_bin,
    output logic                    conv_sign,
    input  logic                    conv_ready,
    input  logic                    conv_done_tick,
    input  logic [BCD_N*4-1:0]      conv_bcd,
    output logic [CH_N*BCD_N*4-1:0] out_bcd,
    output logic [CH_N-1:0]         out_neg,
    output logic [CH_N-1:0]         out_valid,
    output logic [CH_N-1:0]         upd_tick,
    output logic                    err_tick
);

    localparam int IDX_W = ch_idx_w(CH_N);
    localparam int RES_W = BCD_N * 4;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        ch_q, ch_d;
    logic [BIN_N-1:0]        bin_q, bin_d;
    logic                    sign_q, sign_d;
    logic [RES_W-1:0]        res_q, res_d;
    logic [CH_N-1:0]         ack_q, ack_d;
    logic                    start_q, start_d;
    logic [CH_N*RES_W-1:0]   out_bcd_q, out_bcd_d;
    logic [CH_N-1:0]         out_neg_q, out_neg_d;
    logic [CH_N-1:0]         out_valid_q, out_valid_d;
    logic [CH_N-1:0]         upd_q, upd_d;

`ifdef BCD_CONV_SCHED_TIMEOUT_EN
    localparam int TO_LIM = timeout_cycles(BCD_N);
    localparam int TO_W   = $clog2(TO_LIM);
    logic [TO_W-1:0]         to_cnt_q, to_cnt_d;
    logic                    err_q, err_d;
`endif

    logic [CH_N-1:0]         arb_grant;
    logic [IDX_W-1:0]        arb_idx;
    logic                    arb_any;

    bcd_conv_sched_rr_arbiter #(
        .CH_N  (CH_N),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // Next-state and next-output logic for the scheduler FSM.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        ch_d        = ch_q;
        bin_d       = bin_q;
        sign_d      = sign_q;
        res_d       = res_q;
        ack_d       = '0;
        start_d     = 1'b0;
        out_bcd_d   = out_bcd_q;
        out_neg_d   = out_neg_q;
        out_valid_d = out_valid_q;
        upd_d       = '0;
`ifdef BCD_CONV_SCHED_TIMEOUT_EN
        to_cnt_d    = to_cnt_q;
        err_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // Operand is sampled in the grant cycle; ack/start follow
                // as registered pulses during ISSUE.
                if (arb_any && conv_ready) begin
                    ch_d    = arb_idx;
                    bin_d   = bin_in[int'(arb_idx)*BIN_N +: BIN_N];
                    sign_d  = sign_in[arb_idx];
                    ack_d   = arb_grant;
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                ptr_d   = (ch_q == IDX_W'(CH_N - 1)) ? '0 : ch_q + IDX_W'(1);
                state_d = ST_WAIT;
`ifdef BCD_CONV_SCHED_TIMEOUT_EN
                to_cnt_d = '0;
`endif
            end
            ST_WAIT: begin
                // upd_tick is raised here so it is high during STORE,
                // the cycle whose closing edge writes the slot.
                if (conv_done_tick) begin
                    res_d       = conv_bcd;
                    upd_d[ch_q] = 1'b1;
                    state_d     = ST_STORE;
                end else begin
`ifdef BCD_CONV_SCHED_TIMEOUT_EN
                    if (to_cnt_q == TO_W'(TO_LIM - 1)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                        state_d  = ST_WAIT;
                    end
`else
                    state_d = ST_WAIT;
`endif
                end
            end
            ST_STORE: begin
                out_bcd_d[int'(ch_q)*RES_W +: RES_W] = res_q;
                out_neg_d[ch_q]   = sign_q;
                out_valid_d[ch_q] = 1'b1;
                state_d           = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            ch_q        <= '0;
            bin_q       <= '0;
            sign_q      <= 1'b0;
            res_q       <= '0;
            ack_q       <= '0;
            start_q     <= 1'b0;
            out_bcd_q   <= '0;
            out_neg_q   <= '0;
            out_valid_q <= '0;
            upd_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            ch_q        <= ch_d;
            bin_q       <= bin_d;
            sign_q      <= sign_d;
            res_q       <= res_d;
            ack_q       <= ack_d;
            start_q     <= start_d;
            out_bcd_q   <= out_bcd_d;
            out_neg_q   <= out_neg_d;
            out_valid_q <= out_valid_d;
            upd_q       <= upd_d;
        end
    end

`ifdef BCD_CONV_SCHED_TIMEOUT_EN
    // Timeout counter and error pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end
    assign err_tick = err_q;
`else
    assign err_tick = 1'b0;
`endif

    assign ack        = ack_q;
    assign conv_start = start_q;
    assign conv_bin   = bin_q;
    assign conv_sign  = sign_q;
    assign out_bcd    = out_bcd_q;
    assign out_neg    = out_neg_q;
    assign out_valid  = out_valid_q;
    assign upd_tick   = upd_q;

endmodule

// File: doc/bcd_conv_sched.md
# bcd_conv_sched

Round-robin scheduler that shares one signed binary-to-BCD converter among CH_N requesters (gauge readout channels). It accepts per-channel convert requests, sequences the converter's start/done handshake, and latches each result into a per-channel BCD display register with an update pulse. It sits between the sensor-scaling logic and the seven-segment/display drivers.

## Interface
- CH_N, 4: number of requesting channels (2..8).
- BCD_N, 4: BCD digits per result, matching the converter.
- BIN_N, 14: binary input width, matching the converter.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req  in  CH_N  per-channel level request; held with stable data until ack.
- bin_in  in  CH_N*BIN_N  per-channel binary value; channel k at [k*BIN_N +: BIN_N].
- sign_in  in  CH_N  per-channel sign (1 = negative, two's complement bin).
- ack  out  CH_N  one-cycle pulse: channel's request captured.
- conv_start  out  1  one-cycle start pulse to the converter.
- conv_bin  out  BIN_N  value to the converter, held stable from start until done.
- conv_sign  out  1  sign to the converter, held like conv_bin.
- conv_ready  in  1  converter idle.
- conv_done_tick  in  1  converter finished; conv_bcd valid this cycle.
- conv_bcd  in  BCD_N*4  converter result.
- out_bcd  out  CH_N*BCD_N*4  per-channel latched result; channel k at [k*BCD_N*4 +: BCD_N*4].
- out_neg  out  CH_N  per-channel latched sign.
- out_valid  out  CH_N  channel has received at least one result since reset.
- upd_tick  out  CH_N  one-cycle pulse when that channel's out_bcd/out_neg change.
- err_tick  out  1  one-cycle pulse on conversion timeout.

## Operation
- FSM states: IDLE, ISSUE, WAIT, STORE.
- IDLE: if any req and conv_ready, round-robin arbiter picks the first requesting channel at or after ptr; latch channel index, bin_in, sign_in into internal regs; go ISSUE. Otherwise stay.
- ISSUE: ack[ch]=1, conv_start=1 for exactly this cycle; ptr <= ch+1 mod CH_N; go WAIT.
- WAIT: on conv_done_tick capture conv_bcd into result reg, go STORE.
- STORE: write result and latched sign to slot ch; out_valid[ch]<=1; upd_tick[ch]=1; go IDLE.
- conv_bin/conv_sign driven from latched regs in all states; 0 after reset.
- req still high after ack is a new request; it competes in the next IDLE arbitration.
- req dropped before grant: no effect. bin_in changes while req high and unacked: value sampled in the IDLE grant cycle is used.
- Arbitration in a single IDLE cycle only; no grant while conv_ready=0.
- Reset values: all outputs 0, ptr=0, state IDLE. Reset mid-operation aborts without upd_tick; slot contents lost.

## Timing
- Grant decided in IDLE cycle T; ack and conv_start at T+1.
- conv_done_tick at cycle D: out_bcd/out_neg/out_valid visible at D+2; upd_tick asserted in D+1 (STORE), aligned with the write edge.
- With BCD_N=4 converter: done at T+16, outputs at T+18; back-to-back grant earliest at D+2.
- Never more than one conversion outstanding.

## Configuration
- BCD_CONV_SCHED_TIMEOUT_EN defined: WAIT counts cycles; if conv_done_tick is not seen within BCD_N*3+8 cycles, pulse err_tick, leave slot unchanged (no upd_tick), return to IDLE; ptr already advanced.
- Undefined: WAIT waits indefinitely; err_tick tied 0; no counter.

## Structure
- Shared package: FSM state encoding, timeout limit constant, channel-index width function (clog2 of CH_N).
- One sub-module: rr_arbiter (CH_N request vector + ptr in, one-hot grant + index out, combinational).

## Test plan
- ch2 req, bin=1234, sign=0 -> one ack[2], one conv_start with conv_bin=1234; slot 2 = 16'h1234, out_neg[2]=0, out_valid[2]=1, single upd_tick[2].
- ch0..ch3 req together with 1, 22, 333, 4444 -> grant order 0,1,2,3; slots 16'h0001, 16'h0022, 16'h0333, 16'h4444.
- ch0 and ch1 held continuously -> grants alternate 0,1,0,1; no channel granted twice in a row.
- ch0 bin=14'h3FF6, sign=1 -> slot 0 = 16'h0010, out_neg[0]=1.
- reset pulsed during WAIT of ch1 -> all outputs 0, no upd_tick; subsequent ch3 req bin=7 served normally, slot 3 = 16'h0007.
- Macro defined, converter model never asserts done -> err_tick exactly 20 cycles after entering WAIT, FSM in IDLE, slot unchanged; next req served.
